// File: rtl/vga_pattern_timing_gen.sv
// VGA timing generator with a built-in test-pattern source.
// Ports: clk, rst (async, high), ce (pixel enable), mode (pattern select);
//   hsync/vsync/de, x/y, line_start/frame_start, r/g/b, frame_cnt.
module vga_pattern_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int COLOR_BITS = 2,
  parameter int CHECK_LOG2 = 4,
  parameter int XW         = 10,
  parameter int YW         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [1:0]            mode,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic [7:0]            frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int CSHIFT  = 8 - COLOR_BITS;
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);
  localparam logic [COLOR_BITS-1:0] F = '1;

  logic [XW-1:0]         h;
  logic [YW-1:0]         v;
  logic [1:0]            mode_q;
  logic [1:0]            mode_eff;
  logic                  h_last;
  logic                  v_last;
  logic                  first;
  int                    hi;
  int                    vi;
  logic [2:0]            bar_k;
  logic                  chk;
  logic [7:0]            gx;
  logic [7:0]            gy;
  logic [7:0]            diag;
  logic                  de_d;
  logic                  hs_d;
  logic                  vs_d;
  logic [COLOR_BITS-1:0] r_d;
  logic [COLOR_BITS-1:0] g_d;
  logic [COLOR_BITS-1:0] b_d;

  always_comb begin
    hi     = int'(h);
    vi     = int'(v);
    h_last = (hi == H_TOTAL - 1);
    v_last = (vi == V_TOTAL - 1);
    first  = (h == '0) && (v == '0);
    // the pixel at (0,0) already uses the newly sampled mode
    mode_eff = first ? mode : mode_q;
    de_d  = (hi < H_ACTIVE) && (vi < V_ACTIVE);
    hs_d  = (hi >= HS_BEG && hi < HS_END) ? HS_ON : ~HS_ON;
    vs_d  = (vi >= VS_BEG && vi < VS_END) ? VS_ON : ~VS_ON;
    bar_k = 3'(7 - hi / BAR_W);
    chk   = h[CHECK_LOG2] ^ v[CHECK_LOG2];
    gx    = 8'((hi * 256) / H_ACTIVE);
    gy    = 8'((vi * 256) / V_ACTIVE);
    diag  = 8'(hi + vi + int'(frame_cnt));
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    if (de_d) begin
      unique case (mode_eff)
        2'd0: begin
          r_d = bar_k[2] ? F : '0;
          g_d = bar_k[1] ? F : '0;
          b_d = bar_k[0] ? F : '0;
        end
        2'd1: begin
          r_d = chk ? F : '0;
          g_d = chk ? F : '0;
          b_d = chk ? F : '0;
        end
        2'd2: begin
          r_d = COLOR_BITS'(gx >> CSHIFT);
          g_d = COLOR_BITS'(gy >> CSHIFT);
        end
        2'd3: begin
          r_d = COLOR_BITS'(diag >> CSHIFT);
          g_d = COLOR_BITS'(diag >> CSHIFT);
          b_d = COLOR_BITS'(diag >> CSHIFT);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      mode_q      <= '0;
      frame_cnt   <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else if (ce) begin
      x           <= h;
      y           <= v;
      de          <= de_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      line_start  <= (h == '0);
      frame_start <= first;
      r           <= r_d;
      g           <= g_d;
      b           <= b_d;
      mode_q      <= mode_eff;
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule
